// File: rtl/spi_target.sv
// Mode-0 SPI register-access target with four-wire and three-wire (SDIO) read-back.
// Optional: define SPI_TARGET_BURST_EN to continue with auto-incrementing data bytes after the command byte.
module spi_target #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              four_wire,
  input  logic              csb_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  output logic              mosi_o,
  output logic              mosi_oe,
  output logic              miso_o,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                 state_r, state_s;
  logic [SYNC_STAGES-1:0] csb_sync_r, sclk_sync_r, mosi_sync_r;
  logic                   csb_d_r, sclk_d_r;
  logic                   csb_s, sclk_s, mosi_s;
  logic                   csb_fall_s, csb_rise_s, sclk_rise_s, sclk_fall_s;
  logic                   shift_s, byte_end_s, drive_s, trunc_s;
  logic [2:0]             bit_cnt_r;
  logic [6:0]             rx_shift_r;
  logic [7:0]             rx_byte_s;
  logic                   rw_r;
  logic [7:0]             tx_shift_r;
  logic                   load_pend_r;
`ifdef SPI_TARGET_BURST_EN
  logic                   addr_inc_r;
`endif

  // Pin synchronizers plus one delay flop for edge detection. csb resets low so a
  // pin that is already low after reset never looks like a fresh frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csb_sync_r  <= '0;
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      csb_d_r     <= 1'b0;
      sclk_d_r    <= 1'b0;
    end else begin
      csb_sync_r  <= {csb_sync_r[SYNC_STAGES-2:0], csb_i};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_i};
      csb_d_r     <= csb_s;
      sclk_d_r    <= sclk_s;
    end
  end

  assign csb_s       = csb_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign csb_fall_s  = ~csb_s & csb_d_r;
  assign csb_rise_s  = csb_s & ~csb_d_r;
  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;

  assign rx_byte_s  = {rx_shift_r, mosi_s};
  assign shift_s    = sclk_rise_s & ~csb_rise_s & ((state_r == CMD) | (state_r == DATA));
  assign byte_end_s = shift_s & (bit_cnt_r == 3'd7);
  assign drive_s    = sclk_fall_s & ~csb_rise_s & (state_r == DATA) & rw_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (csb_fall_s) state_s = CMD;
        else            state_s = IDLE;
      end
      CMD: begin
        if (csb_rise_s)      state_s = IDLE;
        else if (byte_end_s) state_s = DATA;
        else                 state_s = CMD;
      end
      DATA: begin
        if (csb_rise_s)      state_s = IDLE;
`ifdef SPI_TARGET_BURST_EN
        else                 state_s = DATA;
`else
        else if (byte_end_s) state_s = DONE;
        else                 state_s = DATA;
`endif
      end
      DONE: begin
        if (csb_rise_s) state_s = IDLE;
        else            state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // A frame is truncated when csb returns high before the data byte completes.
  always_comb begin
    trunc_s = 1'b0;
    if (csb_rise_s) begin
      case (state_r)
        CMD:     trunc_s = 1'b1;
`ifdef SPI_TARGET_BURST_EN
        DATA:    trunc_s = (bit_cnt_r != 3'd0);
`else
        DATA:    trunc_s = 1'b1;
`endif
        default: trunc_s = 1'b0;
      endcase
    end else begin
      trunc_s = 1'b0;
    end
  end

  // Receive path: bit counting, command decode and register strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 7'd0;
      rw_r       <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= 8'h00;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SPI_TARGET_BURST_EN
      addr_inc_r <= 1'b0;
`endif
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= trunc_s;
      if (csb_rise_s || (state_r == IDLE)) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_s) begin
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        rx_shift_r <= rx_byte_s[6:0];
        if (byte_end_s && (state_r == CMD)) begin
          rw_r      <= rx_byte_s[7];
          reg_addr  <= rx_byte_s[ADDR_W-1:0];
          reg_rd_en <= rx_byte_s[7];
`ifdef SPI_TARGET_BURST_EN
          addr_inc_r <= 1'b0;
`endif
        end else if (byte_end_s && rw_r) begin
`ifdef SPI_TARGET_BURST_EN
          // Prefetch the next byte so it is ready for the very next fall.
          reg_rd_en <= 1'b1;
          reg_addr  <= reg_addr + ADDR_W'(1);
`endif
        end else if (byte_end_s) begin
          reg_wdata <= rx_byte_s;
          reg_wr_en <= 1'b1;
`ifdef SPI_TARGET_BURST_EN
          if (addr_inc_r) reg_addr <= reg_addr + ADDR_W'(1);
          addr_inc_r <= 1'b1;
`endif
        end
      end
    end
  end

  // Transmit path: load read data after the strobe, present one bit per sclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_r  <= 8'h00;
      load_pend_r <= 1'b0;
      mosi_o      <= 1'b0;
      mosi_oe     <= 1'b0;
      miso_o      <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      load_pend_r <= reg_rd_en;
      if (load_pend_r) begin
        tx_shift_r <= reg_rdata;
      end else if (drive_s) begin
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      end
      if (csb_rise_s) begin
        mosi_o  <= 1'b0;
        mosi_oe <= 1'b0;
        miso_o  <= 1'b0;
        miso_oe <= 1'b0;
      end else if (drive_s) begin
        if (four_wire) begin
          miso_o  <= tx_shift_r[7];
          miso_oe <= 1'b1;
        end else begin
          mosi_o  <= tx_shift_r[7];
          mosi_oe <= 1'b1;
        end
      end
    end
  end

endmodule
